// File: rtl/saturn_jump_decoder_if.sv
// saturn_jump_decoder_if: nibble stream in, jump request out.
// master drives the stream, slave is the decoder.
interface saturn_jump_decoder_if;
  logic       i_clk_en;
  logic [3:0] i_phases;
  logic       i_bus_busy;
  logic [3:0] i_nibble;
  logic       i_instr_start;
  logic       i_carry;
  logic       o_jump_instr;
  logic [2:0] o_jump_length;
  logic       o_push_pc;
  logic       o_busy;
  logic       o_skip;
  logic       o_jump_done;

  modport master (
    output i_clk_en, i_phases, i_bus_busy,
    output i_nibble, i_instr_start, i_carry,
    input  o_jump_instr, o_jump_length, o_push_pc,
    input  o_busy, o_skip, o_jump_done
  );

  modport slave (
    input  i_clk_en, i_phases, i_bus_busy,
    input  i_nibble, i_instr_start, i_carry,
    output o_jump_instr, o_jump_length, o_push_pc,
    output o_busy, o_skip, o_jump_done
  );
endinterface

// File: rtl/saturn_jump_decoder.sv
// saturn_jump_decoder: spots GOC/GONC/GOTO/GOSUB/8C-8F jumps
// and holds the request to the PC block until it executes.
module saturn_jump_decoder (
  input logic            i_clk,
  input logic            i_reset,
  saturn_jump_decoder_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, OP8, OFFSET, EXEC, SKIP
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] len_q, len_d;
  logic       jump_q, jump_d;
  logic       push_q, push_d;
  logic       busy_q, busy_d;
  logic       skip_q, skip_d;
  logic       done_q, done_d;

  logic step, sample, rel, taken;

  assign step   = bus.i_clk_en && !bus.i_bus_busy;
  assign sample = step && (bus.i_phases == 4'b0100);
  assign rel    = step && (bus.i_phases == 4'b1000);
  // 4 (GOC) jumps on carry, 5 (GONC) on no carry
  assign taken  = bus.i_carry ^ bus.i_nibble[0];

  // next-state and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    jump_d  = jump_q;
    push_d  = push_q;
    busy_d  = busy_q;
    skip_d  = skip_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample && bus.i_instr_start) begin
          case (bus.i_nibble)
            4'h4, 4'h5: begin
              busy_d = 1'b1;
              cnt_d  = 3'd0;
              if (taken) begin
                jump_d  = 1'b1;
                len_d   = 3'd1;
                push_d  = 1'b0;
                state_d = OFFSET;
              end else begin
                skip_d  = 1'b1;
                state_d = SKIP;
              end
            end
            4'h6, 4'h7: begin
              jump_d  = 1'b1;
              len_d   = 3'd2;
              push_d  = bus.i_nibble[0];
              busy_d  = 1'b1;
              cnt_d   = 3'd0;
              state_d = OFFSET;
            end
            4'h8: state_d = OP8;
            default: state_d = IDLE;
          endcase
        end
      end
      OP8: begin
        if (sample) begin
          state_d = IDLE;
          if (bus.i_nibble[3:2] == 2'b11) begin
            jump_d  = 1'b1;
            len_d   = bus.i_nibble[0] ? 3'd4 : 3'd3;
            push_d  = bus.i_nibble[1];
            busy_d  = 1'b1;
            cnt_d   = 3'd0;
            state_d = OFFSET;
          end
        end
      end
      OFFSET: begin
        if (sample) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == len_q) begin
            cnt_d   = 3'd0;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (rel) begin
          done_d  = 1'b1;
          jump_d  = 1'b0;
          push_d  = 1'b0;
          busy_d  = 1'b0;
          len_d   = 3'd0;
          state_d = IDLE;
        end
      end
      SKIP: begin
        if (sample) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_d   = 3'd0;
            skip_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register, reset wins over any update
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      len_q   <= 3'd0;
      jump_q  <= 1'b0;
      push_q  <= 1'b0;
      busy_q  <= 1'b0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      jump_q  <= jump_d;
      push_q  <= push_d;
      busy_q  <= busy_d;
      skip_q  <= skip_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_jump_instr  = jump_q;
  assign bus.o_jump_length = len_q;
  assign bus.o_push_pc     = push_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_skip        = skip_q;
  assign bus.o_jump_done   = done_q;
endmodule

// File: doc/saturn_jump_decoder.md
Name: saturn_jump_decoder

Overview:
- Jump-class instruction decoder; sits directly upstream of the PC/RSTK block and drives its jump_instr, jump_length and push_pc inputs.
- Watches the instruction nibble stream from the main decoder and recognises GOC/GONC/GOTO/GOSUB/GOLONG/GOVLNG/GOSUBL/GOSBVL.
- Holds the jump request stable for the whole offset-collection and execute window.
- Swallows the operand nibbles of a GOC/GONC that is not taken.

Parameters:
none

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous reset, active-high
i_clk_en  input  1  clock enable; all state advances gated by it
i_phases  input  4  one-hot phase strobe (0..3), one phase per enabled clock
i_bus_busy  input  1  bus stall; no state advances while high
i_nibble  input  4  current instruction nibble, valid in phase 2
i_instr_start  input  1  high with the first nibble of every instruction
i_carry  input  1  CPU carry flag, sampled with GOC/GONC opcode nibble
o_jump_instr  output  1  jump request to PC/RSTK block
o_jump_length  output  3  1=rel2, 2=rel3, 3=rel4, 4=abs5 (offset nibble count minus 1)
o_push_pc  output  1  push return address (GOSUB family)
o_busy  output  1  decoder owns current nibble stream; main decoder must ignore nibbles
o_skip  output  1  not-taken conditional jump operand nibbles being discarded
o_jump_done  output  1  one-clock pulse when jump executes

Behaviour:
- Step condition: i_clk_en && !i_bus_busy. Sampling occurs only on a step with i_phases[2]; release occurs only on a step with i_phases[3].
- Reset: all outputs 0, o_jump_length=0, state IDLE, counter 0. Reset overrides any same-cycle update. Reset mid-jump aborts to IDLE with outputs cleared.
- States: IDLE, OP8, OFFSET, EXEC, SKIP. Counter is 3 bits.
- IDLE: sample with i_instr_start:
  - 4 (GOC) / 5 (GONC): if taken (carry=1 / carry=0), set o_jump_instr=1, length=1, push=0, go to OFFSET. If not taken, set o_skip=1, counter=0, go to SKIP.
  - 6 (GOTO): length=2, push=0, go to OFFSET.
  - 7 (GOSUB): length=2, push=1, go to OFFSET.
  - 8: go to OP8; o_busy stays 0.
  - Any other nibble: remain in IDLE.
  - Sample without i_instr_start: ignored.
- OP8: next sample, regardless of i_instr_start:
  - C: length=3, push=0.
  - D: length=4, push=0.
  - E: length=3, push=1.
  - F: length=4, push=1.
  - For C-F: set o_jump_instr=1 and go to OFFSET.
  - Other nibble: back to IDLE, no outputs.
- Entering OFFSET: o_busy=1, counter=0. o_jump_instr is set on the phase-2 edge, so it is visible by the following phase 3 (PC block starts decode there).
- OFFSET: each sample increments counter. When the sampling counter equals o_jump_length (length+1 nibbles consumed), go to EXEC.
- EXEC: on next phase-3 step, pulse o_jump_done for one clock, clear o_jump_instr, o_push_pc, o_busy, o_jump_length; go to IDLE.
- o_jump_length and o_push_pc are held constant from OFFSET entry through EXEC release.
- SKIP: o_busy=1, o_skip=1. Discards 2 samples, then clears o_skip/o_busy on that same edge and returns to IDLE. o_jump_instr stays 0 throughout.
- i_instr_start while not IDLE: ignored. The offset/operand nibble is consumed normally.
- i_bus_busy high: freezes state, counter and outputs. A phase strobe coinciding with busy is lost; no catch-up.
- A new instruction may start on the phase-2 sample after the EXEC release. Back-to-back jumps are supported.
- Latency, opcode nibble to o_jump_instr: same step.
- Jump window: o_jump_instr high from opcode sample through the phase-3 release after the last offset nibble.

Test Plan:
- GOTO: start+6, then 4,3,2 on successive phase-2 samples -> o_jump_instr=1 and length=2 after first sample, push=0. Stays high for 3 offset samples, drops on next phase 3 with one o_jump_done pulse.
- GOSBVL: start+8, F, then 5,4,3,2,1 -> length=4, push=1, o_busy=1 during 5 offset nibbles. Cleared after the 5th nibble's following phase 3.
- GOC: carry=1, start+4, 0x,1x -> length=1 jump. Repeat with carry=0 -> o_jump_instr never asserted, o_skip=1 for exactly 2 samples, then IDLE.
- Non-jump and 8-prefix: start+A -> no output change. Start+8 then 2 -> returns to IDLE, no outputs.
- Stall: i_bus_busy=1 across two phase-2 strobes mid-GOLONG (8C) -> counter frozen; jump completes only after 4 unstalled offset samples.
- Reset: assert i_reset during OFFSET of GOSUB -> next clock all outputs 0, state IDLE. Fresh start+6 decodes normally.
